ifetch_queue: RTL and testbench

Instruction-fetch front end that consumes the PC stream and delivers instructions to decode.
- Issues sequential word fetches to instruction memory over a request/grant, in-order-response interface.
- Buffers the returned words, each with its PC, in a small FIFO.
- Presents them to decode with valid/ready.
- On a branch redirect from the PC/branch logic (target = PC+4+sext(imm16<<2)), flushes the FIFO and discards stale in-flight responses.

---
 rtl/ifetch_queue_if.sv | 25 ++
 rtl/ifetch_queue.sv | 115 +++++++++++
 tb/tb_ifetch_queue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bundle: redirect from branch logic, instruction-memory request/response,
// and the decode-side valid/ready instruction stream.
interface ifetch_queue_if;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   modport master (
      input  redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
      output mem_req, mem_addr, inst_valid, inst, inst_pc
   );

   modport slave (
      output redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
      input  mem_req, mem_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/ifetch_queue.sv
// Sequential instruction fetch with credit-limited requests, a PC-tagged FIFO to decode,
// and redirect handling that flushes the FIFO and drops responses still in flight.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h00400020
) (
   input  logic          clk,
   input  logic          reset,
   ifetch_queue_if.master bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];

   logic [31:0]   target_pc;
   logic [CW:0]   credit_used;
   logic          req;
   logic          grant;
   logic          push;
   logic          pop;
   logic          unused_pc_lsb;

   assign target_pc     = {bus.redirect_pc[31:2], 2'b00};
   assign unused_pc_lsb = ^bus.redirect_pc[1:0];

   // Credits cover entries held plus live (non-dropped) requests, so a response always fits.
   assign credit_used = {1'b0, cnt_q} + {1'b0, outst_q - drop_q};

   assign req   = !reset && (state_q != ST_BOOT) && !bus.redirect
                  && (credit_used < (CW + 1)'(DEPTH));
   assign grant = req && bus.mem_gnt;
   assign push  = bus.mem_rvalid && (drop_q == '0) && !bus.redirect;
   assign pop   = (cnt_q != '0) && bus.inst_ready && !bus.redirect;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
      outst_d    = outst_q + CW'(grant) - CW'(bus.mem_rvalid);
      drop_d     = drop_q;
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      if (grant) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
         resp_pc_d = resp_pc_q + 32'd4;
      end
      if (bus.mem_rvalid && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end

      if (bus.redirect) begin
         fetch_pc_d = target_pc;
         resp_pc_d  = target_pc;
         cnt_d      = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         drop_d     = outst_q - CW'(bus.mem_rvalid);
      end

      state_d = (drop_d != '0) ? ST_FLUSH : ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         cnt_q      <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         cnt_q      <= cnt_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         pc_mem[wr_ptr_q]   <= resp_pc_q;
         inst_mem[wr_ptr_q] <= bus.mem_rdata;
      end
   end

   assign bus.mem_req    = req;
   assign bus.mem_addr   = fetch_pc_q;
   assign bus.inst_valid = (cnt_q != '0);
   assign bus.inst       = (cnt_q != '0) ? inst_mem[rd_ptr_q] : '0;
   assign bus.inst_pc    = (cnt_q != '0) ? pc_mem[rd_ptr_q]   : '0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: in-order memory model, epoch-tagged reference model
// and a scoreboard queue compared by an independent decode-side monitor.
module tb_ifetch_queue;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h00400020;
   localparam logic [31:0] XORK     = 32'hFFFF0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ifetch_queue_if bus();

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   req_t        pend[$];
   ent_t        sb[$];
   logic [31:0] m_fetch_pc = RESET_PC;
   int          m_epoch    = 0;
   bit          m_boot     = 1'b1;
   int          cyc        = 0;
   int          last_due   = 0;

   int          lat_lo = 1, lat_hi = 1, gnt_pct = 100, rdy_pct = 100, redir_pct = 0;
   bit          redir_on_rv = 1'b0;
   bit          do_reset    = 1'b0;
   bit          force_redir = 1'b0;
   logic [31:0] force_pc    = '0;
   bit          prev_reset  = 1'b1;
   bit          started     = 1'b0;
   int          grants      = 0;
   int          delivered   = 0;

   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int live_outstanding();
      int n = 0;
      foreach (pend[i]) if (pend[i].epoch == m_epoch) n++;
      return n;
   endfunction

   // One clock cycle: drive at negedge, check request side at +1, update model at +3.
   task automatic step();
      bit   rv, rdir, granted, exp_req;
      int   lat, due;
      req_t r;
      @(negedge clk);
      cyc++;
      rv   = !do_reset && (pend.size() != 0) && (pend[0].due <= cyc);
      rdir = !do_reset && (force_redir || (redir_on_rv && rv && pend.size() == 2)
                           || ($urandom_range(99) < redir_pct));
      reset           = do_reset;
      bus.redirect    = rdir;
      bus.redirect_pc = force_redir ? force_pc : $urandom;
      bus.mem_gnt     = ($urandom_range(99) < gnt_pct);
      bus.mem_rvalid  = rv;
      bus.mem_rdata   = rv ? (pend[0].addr ^ XORK) : $urandom;
      bus.inst_ready  = ($urandom_range(99) < rdy_pct);
      assert (!(bus.mem_rvalid && pend.size() == 0));
      #1;
      if (prev_reset && !do_reset) begin
         check32("rst_inst_valid", bus.inst_valid, 0);
         check32("rst_inst", bus.inst, 0);
         check32("rst_inst_pc", bus.inst_pc, 0);
         check32("rst_mem_addr", bus.mem_addr, RESET_PC);
      end
      exp_req = !do_reset && !m_boot && !rdir && (sb.size() + live_outstanding() < DEPTH);
      check32("mem_req", bus.mem_req, exp_req);
      if (bus.mem_req && exp_req) check32("mem_addr", bus.mem_addr, m_fetch_pc);
      granted = bus.mem_req && bus.mem_gnt;
      #2;
      if (do_reset) begin
         pend.delete();
         sb.delete();
         m_fetch_pc = RESET_PC;
         m_boot     = 1'b1;
         m_epoch++;
         last_due   = cyc;
         started    = 1'b1;
      end else begin
         if (rv) r = pend.pop_front();
         if (rdir) begin
            m_epoch++;
            sb.delete();
            m_fetch_pc = {bus.redirect_pc[31:2], 2'b00};
         end else if (rv && r.epoch == m_epoch) begin
            sb.push_back('{r.addr, r.addr ^ XORK});
         end
         if (granted) begin
            lat = $urandom_range(lat_hi, lat_lo);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend.push_back('{m_fetch_pc, m_epoch, due});
            last_due   = due;
            m_fetch_pc = m_fetch_pc + 32'd4;
            grants++;
         end
         m_boot = 1'b0;
      end
      prev_reset = do_reset;
   endtask

   task automatic do_rst(input int n);
      do_reset = 1'b1;
      repeat (n) step();
      do_reset = 1'b0;
   endtask

   task automatic set_knobs(input int llo, input int lhi, input int g, input int rd, input int rp);
      lat_lo = llo; lat_hi = lhi; gnt_pct = g; rdy_pct = rd; redir_pct = rp;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      force_redir = 1'b1;
      force_pc    = pc;
      step();
      force_redir = 1'b0;
   endtask

   // Decode-side monitor: head must match the scoreboard front; pops when decode accepts.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (started) begin
            check32("inst_valid", bus.inst_valid, (sb.size() != 0));
            if (bus.inst_valid && sb.size() != 0) begin
               check32("inst_pc", bus.inst_pc, sb[0].pc);
               check32("inst", bus.inst, sb[0].ins);
               if (bus.inst_ready && !bus.redirect && !reset) begin
                  void'(sb.pop_front());
                  delivered++;
               end
            end
         end
      end
   end

   initial begin
      bit reached;
      reset           = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.mem_gnt     = 1'b0;
      bus.mem_rvalid  = 1'b0;
      bus.mem_rdata   = '0;
      bus.inst_ready  = 1'b0;

      // Single-cycle memory, decode always ready: one instruction per cycle after fill.
      set_knobs(1, 1, 100, 100, 0);
      do_rst(2);
      delivered = 0;
      repeat (40) step();
      check32("throughput", delivered, 37);

      // Decode stalled: exactly DEPTH requests, then resume.
      do_rst(1);
      set_knobs(3, 3, 100, 0, 0);
      grants = 0;
      repeat (20) step();
      check32("credit_cap", grants, DEPTH);
      rdy_pct = 100;
      repeat (20) step();

      // Redirect with three requests in flight.
      do_rst(1);
      set_knobs(3, 3, 100, 100, 0);
      reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
         step();
         reached = (live_outstanding() == 3);
      end
      check32("reach_3_outstanding", reached, 1);
      redirect_to(32'h00400100);
      repeat (20) step();

      // Redirect coinciding with a response while two are outstanding.
      set_knobs(2, 2, 100, 100, 0);
      redir_on_rv = 1'b1;
      repeat (12) step();
      redir_on_rv = 1'b0;
      repeat (12) step();

      // Back-to-back redirects: only the last target survives.
      set_knobs(2, 3, 100, 100, 0);
      repeat (6) step();
      redirect_to(32'h00400200);
      redirect_to(32'h00400303);
      repeat (20) step();

      // Reset while flushing.
      do_rst(1);
      set_knobs(4, 4, 100, 0, 0);
      repeat (4) step();
      redirect_to(32'h00400500);
      do_rst(1);
      rdy_pct = 100;
      repeat (20) step();

      // Randomized traffic with occasional redirects and resets.
      for (int round = 0; round < 6; round++) begin
         set_knobs(1, $urandom_range(5, 1), $urandom_range(100, 30),
                   $urandom_range(100, 20), 4);
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(199) == 0) do_rst(1);
            else step();
         end
      end

      redir_pct = 0;
      repeat (4) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
